// File: rtl/xor_mem_frontend_if.sv
// xor_mem_frontend_if: client-side write/read bus of the XOR memory front-end
interface xor_mem_frontend_if #(parameter int ADDR_WIDTH = 10, parameter int DATA_WIDTH = 8);
  logic [1:0] wr_valid, wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr1, wr_addr2;
  logic [DATA_WIDTH-1:0] wr_data1, wr_data2;
  logic [3:0] rd_en, rd_valid;
  logic [ADDR_WIDTH-1:0] rd_addr1, rd_addr2, rd_addr3, rd_addr4;
  logic [DATA_WIDTH-1:0] rd_data1, rd_data2, rd_data3, rd_data4;
  modport master (
    output wr_valid, wr_addr1, wr_addr2, wr_data1, wr_data2, rd_en,
           rd_addr1, rd_addr2, rd_addr3, rd_addr4,
    input  wr_ready, rd_valid, rd_data1, rd_data2, rd_data3, rd_data4
  );
  modport slave (
    input  wr_valid, wr_addr1, wr_addr2, wr_data1, wr_data2, rd_en,
           rd_addr1, rd_addr2, rd_addr3, rd_addr4,
    output wr_ready, rd_valid, rd_data1, rd_data2, rd_data3, rd_data4
  );
endinterface

// File: rtl/xor_mem_frontend.sv
// xor_mem_frontend: hazard-hiding client front-end for the 4R/2W XOR multi-port RAM
module xor_mem_frontend #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  xor_mem_frontend_if.slave     bus,
  output logic [1:0]            o_mem_en_w,
  output logic [ADDR_WIDTH-1:0] o_mem_wa1,
  output logic [ADDR_WIDTH-1:0] o_mem_wa2,
  output logic [DATA_WIDTH-1:0] o_mem_w1,
  output logic [DATA_WIDTH-1:0] o_mem_w2,
  output logic [ADDR_WIDTH-1:0] o_mem_ra1,
  output logic [ADDR_WIDTH-1:0] o_mem_ra2,
  output logic [ADDR_WIDTH-1:0] o_mem_ra3,
  output logic [ADDR_WIDTH-1:0] o_mem_ra4,
  input  logic [DATA_WIDTH-1:0] i_mem_r1,
  input  logic [DATA_WIDTH-1:0] i_mem_r2,
  input  logic [DATA_WIDTH-1:0] i_mem_r3,
  input  logic [DATA_WIDTH-1:0] i_mem_r4,
  output logic [15:0]           o_drop_cnt
);
  logic [ADDR_WIDTH-1:0] w_wa [2];
  logic [DATA_WIDTH-1:0] w_wd [2];
  logic [ADDR_WIDTH-1:0] w_ra [4];
  logic [DATA_WIDTH-1:0] w_mr [4];
  logic [1:0] w_ready, w_iss, w_en;
  logic w_coll;
  logic [1:0] r_prev_v;
  logic [ADDR_WIDTH-1:0] r_prev_a [2];
  logic [DATA_WIDTH-1:0] r_prev_d [2];
  logic [3:0] r_rv;
  logic [15:0] r_drop;
  always_comb begin
    w_wa[0] = bus.wr_addr1;
    w_wa[1] = bus.wr_addr2;
    w_wd[0] = bus.wr_data1;
    w_wd[1] = bus.wr_data2;
    w_ra[0] = bus.rd_addr1;
    w_ra[1] = bus.rd_addr2;
    w_ra[2] = bus.rd_addr3;
    w_ra[3] = bus.rd_addr4;
    w_mr[0] = i_mem_r1;
    w_mr[1] = i_mem_r2;
    w_mr[2] = i_mem_r3;
    w_mr[3] = i_mem_r4;
    // a port stalls when the other port wrote the same address last cycle
    w_ready = rst ? 2'b00 : {!(r_prev_v[0] && r_prev_a[0] == w_wa[1]),
                             !(r_prev_v[1] && r_prev_a[1] == w_wa[0])};
    w_iss = bus.wr_valid & w_ready;
    w_coll = &w_iss && w_wa[0] == w_wa[1];
    w_en = {w_iss[1], w_iss[0] && !w_coll};
    bus.wr_ready = w_ready;
    bus.rd_valid = r_rv;
    o_mem_en_w = w_en;
    o_mem_wa1 = w_wa[0];
    o_mem_wa2 = w_wa[1];
    o_mem_w1 = w_wd[0];
    o_mem_w2 = w_wd[1];
    o_mem_ra1 = w_ra[0];
    o_mem_ra2 = w_ra[1];
    o_mem_ra3 = w_ra[2];
    o_mem_ra4 = w_ra[3];
    o_drop_cnt = r_drop;
  end
  always_ff @(posedge clk) begin
    r_prev_v <= rst ? 2'b00 : w_en;
    r_prev_a[0] <= w_wa[0];
    r_prev_a[1] <= w_wa[1];
    r_prev_d[0] <= w_wd[0];
    r_prev_d[1] <= w_wd[1];
    r_rv <= rst ? 4'b0000 : bus.rd_en;
    r_drop <= rst ? 16'd0 : r_drop + {15'd0, w_coll && r_drop != 16'hFFFF};
  end
  for (genvar k = 0; k < 4; k++) begin : g_rd
    logic [3:0] w_m;
    logic [DATA_WIDTH-1:0] w_fd, w_out, r_fd;
    logic r_hit;
    // newest first: this cycle's port 2, port 1, then last cycle's port 2, port 1
    always_comb begin
      w_m = {r_prev_v[0] && r_prev_a[0] == w_ra[k], r_prev_v[1] && r_prev_a[1] == w_ra[k],
             w_en[0] && w_wa[0] == w_ra[k], w_en[1] && w_wa[1] == w_ra[k]};
      w_fd = w_m[0] ? w_wd[1] : w_m[1] ? w_wd[0] : w_m[2] ? r_prev_d[1] : r_prev_d[0];
      w_out = r_rv[k] ? (r_hit ? r_fd : w_mr[k]) : '0;
    end
    always_ff @(posedge clk) begin
      r_hit <= !rst && |w_m;
      r_fd <= w_fd;
    end
  end
  always_comb begin
    bus.rd_data1 = g_rd[0].w_out;
    bus.rd_data2 = g_rd[1].w_out;
    bus.rd_data3 = g_rd[2].w_out;
    bus.rd_data4 = g_rd[3].w_out;
  end
endmodule
